seg_display_scanner: RTL

Time-multiplexed 7-segment readout for the stopwatch. It reads the BCD digit registers produced by the counter/flip-flop chain, takes a tear-free snapshot once per frame, and scans one digit at a time onto shared segment lines. It includes leading-zero blanking, a fixed decimal point, an invalid-code indication, and a hold (lap-freeze) control.

---
 rtl/seg_display_scanner.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//   Time-multiplexed 7-segment readout for the stopwatch. A tear-free snapshot of the
//   BCD digit registers is taken once per frame. The digits are then scanned one at a
//   time onto shared, active-low segment lines. The block also handles leading-zero
//   blanking, a fixed decimal point, a dash for non-BCD codes and a lap-freeze hold.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   digits_in    BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   hold         1 = keep the current snapshot at frame wrap
//   an           digit enables, active low, one-hot-low while lit
//   seg          segments a..g in bits 0..6, active low
//   dp           decimal point, active low
//   frame_start  one-cycle pulse after the edge that captures the snapshot
module seg_display_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned DP_POS     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    hold,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(NUM_DIGITS);

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [IW-1:0] DP_IDX    = IW'(DP_POS);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fs_q, fs_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    blank_cur;

    // Segment pattern for one digit, seg[6:0] = g..a, active low; non-BCD shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick = (presc_q == PRESC_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    // Scan timing and snapshot capture.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
        snap_d = snap_q;
        if (wrap && !hold) begin
            snap_d = digits_in;
        end
    end

    // upper_zero[i]: snapshot digits i..NUM_DIGITS-1 are all zero (non-BCD counts as nonzero).
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc           = acc & (snap_q[4*i +: 4] == 4'd0);
            upper_zero[i] = acc;
        end
    end

    // Digits at or below the decimal point always show, so 0.00 stays readable.
    always_comb begin
        blank_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank_mask[i] = (i > int'(DP_POS)) && upper_zero[i];
        end
    end

    // Select the digit under scan.
    always_comb begin
        cur_digit = 4'd0;
        blank_cur = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = snap_q[4*i +: 4];
                blank_cur = blank_mask[i];
            end
        end
    end

    // Registered outputs, one cycle behind idx/snapshot.
    always_comb begin
        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = (idx_q != IW'(i));
        end
        seg_d = blank_cur ? 7'h7F : seg_decode(cur_digit);
        dp_d  = (idx_q != DP_IDX);
        fs_d  = wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fs_q    <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule
